// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce_sync slice: FSM encoding and the
// small parameter set used for simulation builds.
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE_LOW  = 2'd0,
    ST_WAIT_HIGH = 2'd1,
    ST_IDLE_HIGH = 2'd2,
    ST_WAIT_LOW  = 2'd3
  } state_t;

  localparam int SIM_STABLE_COUNT = 4;
  localparam int SIM_SYNC_STAGES  = 2;

endpackage

// File: rtl/debounce_sync_if.sv
// Level input and conditioned outputs of the debouncer, grouped as one bundle.
interface debounce_sync_if;

  logic din_async;
  logic dout;
  logic rise_pulse;
  logic fall_pulse;
  logic busy;

  modport master (
    output din_async,
    input  dout, rise_pulse, fall_pulse, busy
  );

  modport slave (
    input  din_async,
    output dout, rise_pulse, fall_pulse, busy
  );

endinterface

// File: rtl/debounce_sync_sync_chain.sv
// Plain flop chain for bringing an asynchronous bit into the clk domain.
// Nothing sits between stages so each flop gets a full period to resolve.
module sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) begin
      ff <= '0;
    end else begin
      ff <= {ff[SYNC_STAGES-2:0], d};
    end
  end

  assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Debouncer: synchronizes din_async, then accepts a new level only after it
// has been seen for STABLE_COUNT consecutive clocks.
//
//   state        | meaning
//   ST_IDLE_LOW  | dout = 0, input agrees
//   ST_WAIT_HIGH | dout = 0, counting consecutive high samples
//   ST_IDLE_HIGH | dout = 1, input agrees
//   ST_WAIT_LOW  | dout = 1, counting consecutive low samples
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int STABLE_COUNT = 50000,
  parameter int CNT_WIDTH    = 16
) (
  input  logic           clk,
  input  logic           rst,
  debounce_sync_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic                 s;
  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 dout_q;
  logic                 rise_q;
  logic                 fall_q;
  logic                 busy_q;

  sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.din_async),
    .q   (s)
  );

  // Strobes default low every cycle; only a completed qualification raises one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE_LOW;
      cnt    <= '0;
      dout_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state)
        ST_IDLE_LOW: begin
          if (s) begin
            state  <= ST_WAIT_HIGH;
            cnt    <= CNT_ONE;
            busy_q <= 1'b1;
          end else begin
            cnt    <= '0;
          end
        end
        ST_WAIT_HIGH: begin
          if (!s) begin
            state  <= ST_IDLE_LOW;
            cnt    <= '0;
            busy_q <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state  <= ST_IDLE_HIGH;
            cnt    <= '0;
            dout_q <= 1'b1;
            rise_q <= 1'b1;
            busy_q <= 1'b0;
          end else begin
            cnt    <= cnt + CNT_ONE;
          end
        end
        ST_IDLE_HIGH: begin
          if (!s) begin
            state  <= ST_WAIT_LOW;
            cnt    <= CNT_ONE;
            busy_q <= 1'b1;
          end else begin
            cnt    <= '0;
          end
        end
        ST_WAIT_LOW: begin
          if (s) begin
            state  <= ST_IDLE_HIGH;
            cnt    <= '0;
            busy_q <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state  <= ST_IDLE_LOW;
            cnt    <= '0;
            dout_q <= 1'b0;
            fall_q <= 1'b1;
            busy_q <= 1'b0;
          end else begin
            cnt    <= cnt + CNT_ONE;
          end
        end
      endcase
    end
  end

  assign bus.dout       = dout_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Self-checking bench for debounce_sync: directed scenarios plus random
// bounce, compared every edge against a run-length reference model.
module tb_debounce_sync;
  import debounce_pkg::*;

  localparam int NS = SIM_SYNC_STAGES;
  localparam int SC = SIM_STABLE_COUNT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  debounce_sync_if bus ();

  debounce_sync #(
    .SYNC_STAGES  (NS),
    .STABLE_COUNT (SC),
    .CNT_WIDTH    (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #50 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference: a delay line for the synchronizer and a count of consecutive
  // samples that disagree with the accepted level.
  bit sh [NS];
  bit acc = 1'b0;
  int run = 0;
  bit m_rise = 1'b0, m_fall = 1'b0, m_busy = 1'b0;

  int edge_no = 0;
  int rise_at = -1;
  int rise_cnt = 0;
  int fall_cnt = 0;
  int busy_cnt = 0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, edge_no, obs, exp);
    end
  endtask

  task automatic step(input bit d, input bit r);
    bit s;
    bus.din_async = d;
    rst = r;
    @(posedge clk);
    edge_no++;
    if (r) begin
      acc = 1'b0; run = 0; m_rise = 1'b0; m_fall = 1'b0; m_busy = 1'b0;
      for (int i = 0; i < NS; i++) sh[i] = 1'b0;
    end else begin
      s = sh[NS-1];
      m_rise = 1'b0; m_fall = 1'b0;
      if (s != acc) begin
        run++;
        if (run == SC) begin
          acc = s; run = 0; m_busy = 1'b0;
          if (s) m_rise = 1'b1; else m_fall = 1'b1;
        end else begin
          m_busy = 1'b1;
        end
      end else begin
        run = 0; m_busy = 1'b0;
      end
      for (int i = NS-1; i > 0; i--) sh[i] = sh[i-1];
      sh[0] = d;
    end
    #1;
    chk("dout", bus.dout, acc);
    chk("rise_pulse", bus.rise_pulse, m_rise);
    chk("fall_pulse", bus.fall_pulse, m_fall);
    chk("busy", bus.busy, m_busy);
    if (bus.rise_pulse === 1'b1) begin rise_at = edge_no; rise_cnt++; end
    if (bus.fall_pulse === 1'b1) fall_cnt++;
    if (bus.busy === 1'b1) busy_cnt++;
  endtask

  task automatic clear_marks();
    rise_at = -1; rise_cnt = 0; fall_cnt = 0; busy_cnt = 0;
  endtask

  initial begin
    int base;
    bit d;
    int hold;
    for (int i = 0; i < NS; i++) sh[i] = 1'b0;
    bus.din_async = 1'b1;

    // 1: reset with input high, then one cycle after release
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    chk("s1_dout_after_rst", bus.dout, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);

    // 2: clean rise, captured at edge 1
    clear_marks();
    base = edge_no;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    chk("s2_rise_latency", (rise_at - base) == (NS + SC), 1'b1);
    chk("s2_single_rise", rise_cnt == 1, 1'b1);

    // 5: fall from dout = 1
    clear_marks();
    base = edge_no;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
    chk("s5_fall_seen", fall_cnt == 1, 1'b1);
    chk("s5_no_rise", rise_cnt == 0, 1'b1);

    // 3: high for only 3 edges
    clear_marks();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
    chk("s3_no_rise", rise_cnt == 0, 1'b1);
    chk("s3_busy_len3", busy_cnt == 3, 1'b1);
    chk("s3_dout_low", bus.dout, 1'b0);

    // 4: bounce 1,1,1,0,1 then held high
    clear_marks();
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    base = edge_no - 1;
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0);
    chk("s4_rise_latency", (rise_at - base) == (NS + SC), 1'b1);
    chk("s4_single_rise", rise_cnt == 1, 1'b1);

    // back to low, then 6: reset mid-qualification
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
    clear_marks();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("s6_busy_cleared", bus.busy, 1'b0);
    base = edge_no;
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0);
    chk("s6_rise_latency", (rise_at - base) == (NS + SC), 1'b1);
    chk("s6_single_rise", rise_cnt == 1, 1'b1);

    // Random bounce with occasional resets
    for (int n = 0; n < 120; n++) begin
      d = 1'($urandom_range(0, 1));
      hold = (($urandom_range(0, 2)) == 0) ? int'($urandom_range(5, 9))
                                            : int'($urandom_range(1, 4));
      for (int k = 0; k < hold; k++)
        step(d, ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0);
      chk("rand_no_double_strobe", bus.rise_pulse & bus.fall_pulse, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/debounce_sync.md
Name: debounce_sync

Overview:
Conditions a raw asynchronous level input (push-button or switch) into a clean, clock-synchronous level. Its output directly drives the D input of the positive-edge flip-flop stage.
- Stage 1: multi-stage synchronizer.
- Stage 2: counter-qualified state machine. It accepts a level change only after the new level has been stable for a programmable number of clocks.
- Also emits one-cycle rise/fall strobes for downstream edge-driven logic.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops (legal range 2..4).
STABLE_COUNT, 50000, consecutive synchronized samples required to accept a new level (must be >= 2).
CNT_WIDTH, 16, stability counter width; must satisfy 2**CNT_WIDTH > STABLE_COUNT.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
din_async  input  1  raw asynchronous level input.
dout  output  1  debounced synchronous level; feeds the flip-flop D input.
rise_pulse  output  1  one-cycle strobe when dout goes 0->1.
fall_pulse  output  1  one-cycle strobe when dout goes 1->0.
busy  output  1  high while a candidate level change is being qualified.

Behaviour:
- Reset: when rst is high at a rising edge, all of the following are cleared:
  - all synchronizer flops = 0, cnt = 0, state = IDLE_LOW;
  - dout = 0, rise_pulse = 0, fall_pulse = 0, busy = 0.
  - rst overrides everything, including mid-qualification. After reset, any level must re-qualify from scratch.
- Synchronizer: din_async shifts through SYNC_STAGES flops. The last flop is s. No logic is placed between synchronizer flops.
- Registered outputs: all outputs are registered; there is no combinational path from din_async.
- State machine: four states. dout = 1 in IDLE_HIGH and WAIT_LOW; busy = 1 in WAIT_HIGH and WAIT_LOW.
  - IDLE_LOW:
    - s = 1: go to WAIT_HIGH, cnt <= 1.
    - otherwise: stay, cnt <= 0.
  - WAIT_HIGH:
    - s = 0: return to IDLE_LOW, cnt <= 0 (glitch rejected, no strobe).
    - s = 1 and cnt == STABLE_COUNT-1: go to IDLE_HIGH, dout <= 1, rise_pulse <= 1, cnt <= 0.
    - otherwise: cnt <= cnt + 1.
  - IDLE_HIGH and WAIT_LOW: exact mirror with s inverted. Completion sets dout <= 0 and fall_pulse <= 1.
- Qualification rule: a level is accepted after exactly STABLE_COUNT consecutive rising edges sample s at the new level. A single opposite sample restarts qualification.
- Latency: number the first edge that captures the new din_async level into synchronizer flop 1 as edge 1. dout and the strobe update at edge SYNC_STAGES + STABLE_COUNT.
- Strobes:
  - rise_pulse and fall_pulse are each high for exactly one cycle, in the same cycle dout first shows the new value.
  - They are never high simultaneously.
  - They are cleared to 0 on every other cycle.
- Counter: cnt never exceeds STABLE_COUNT-1 and never wraps. Overflow is impossible under the parameter constraints.
- Sustained bounce: if din toggles faster than STABLE_COUNT indefinitely, dout holds its last accepted value and busy toggles with the pending state.

Decomposition:
- Shared package debounce_pkg holds:
  - state encoding constants ST_IDLE_LOW, ST_WAIT_HIGH, ST_IDLE_HIGH, ST_WAIT_LOW (2-bit);
  - simulation defaults SIM_STABLE_COUNT = 4 and SIM_SYNC_STAGES = 2.
- One sub-module, sync_chain (parameter SYNC_STAGES; ports clk, rst, d, q), holds the synchronizer flops. It is reusable for other asynchronous inputs.
- The FSM and counter live in debounce_sync.

Test Plan:
All scenarios use SYNC_STAGES = 2 and STABLE_COUNT = 4. A 100 ns period is sufficient; the bench must check values at every edge.
1. rst high 2 cycles with din_async = 1 -> dout = 0, rise_pulse = 0, fall_pulse = 0, busy = 0 throughout and in the first cycle after release.
2. din_async 0->1 captured at edge 1, then held -> busy = 1 after edge 3; dout = 1 and rise_pulse = 1 after edge 6; rise_pulse = 0 after edge 7; busy = 0 after edge 6.
3. din_async high for 3 edges only, then low -> dout stays 0; rise_pulse never asserts; busy high for exactly 3 cycles.
4. Bounce pattern 1,1,1,0,1 then held high -> qualification restarts; dout = 1 exactly 6 edges after the final 0->1 capture; only one rise_pulse.
5. From dout = 1, din_async 1->0 held -> dout = 0 and fall_pulse = 1 after edge 6; rise_pulse stays 0.
6. rst asserted for one cycle while in WAIT_HIGH with cnt = 2, din_async still 1 -> all outputs 0 next cycle; dout rises only 6 edges after rst deassertion.
